// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;
  localparam logic [3:0] AN_OFF     = 4'hF;

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// BCD-plus-dash to active-low seven-segment pattern (bit 6 = g ... bit 0 = a).
module seg_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'd0:    seg_n = 7'h40;
        4'd1:    seg_n = 7'h79;
        4'd2:    seg_n = 7'h24;
        4'd3:    seg_n = 7'h30;
        4'd4:    seg_n = 7'h19;
        4'd5:    seg_n = 7'h12;
        4'd6:    seg_n = 7'h02;
        4'd7:    seg_n = 7'h78;
        4'd8:    seg_n = 7'h00;
        4'd9:    seg_n = 7'h10;
        4'd15:   seg_n = SEG_DASH;
        default: seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with dead time between digits and a
// double-buffered value register that only swaps at frame boundaries.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV      = 1000,
  parameter int DEAD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lzb,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_o
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(DIV - DEAD_CYC - 1);

  state_t        state, state_next;
  logic [1:0]    digit, digit_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   disp, pend;
  logic          pend_full;
  logic          commit, frame_next;
  logic [6:0]    seg_next, dec_seg;
  logic [3:0]    an_next;
  logic [3:0]    zero_vec, blank_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign zero_vec[gi] = (disp[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // A digit is a leading zero only if every more significant digit is zero too.
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = lzb & zero_vec[3];
    blank_vec[2] = blank_vec[3] & zero_vec[2];
    blank_vec[1] = blank_vec[2] & zero_vec[1];
  end

  seg_decode u_decode (
    .code  (disp[{digit_next, 2'b00} +: 4]),
    .blank (blank_vec[digit_next]),
    .seg_n (dec_seg)
  );

  always_comb begin
    state_next = state;
    digit_next = digit;
    cnt_next   = cnt;
    frame_next = 1'b0;
    commit     = 1'b0;
    an_next    = AN_OFF;
    seg_next   = SEG_BLANK;
    if (!en) begin
      state_next = ST_IDLE;
      digit_next = 2'd0;
      cnt_next   = '0;
      commit     = (state == ST_IDLE);
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_DEAD;
          digit_next = 2'd0;
          cnt_next   = '0;
          commit     = 1'b1;
        end
        ST_DEAD: begin
          if (cnt == DEAD_LAST) begin
            state_next = ST_SCAN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          if (cnt == SCAN_LAST) begin
            state_next = ST_DEAD;
            cnt_next   = '0;
            digit_next = digit + 2'd1;
            if (digit == 2'd3) begin
              frame_next = 1'b1;
              commit     = 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          digit_next = 2'd0;
          cnt_next   = '0;
        end
      endcase
    end
    // Outputs are registered from the next state so they move with the state.
    if (state_next == ST_SCAN) begin
      an_next             = AN_OFF;
      an_next[digit_next] = 1'b0;
      seg_next            = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      digit     <= 2'd0;
      cnt       <= '0;
      disp      <= 16'h0000;
      pend      <= 16'h0000;
      pend_full <= 1'b0;
      an_n      <= AN_OFF;
      seg_n     <= SEG_BLANK;
      frame_o   <= 1'b0;
    end else begin
      state   <= state_next;
      digit   <= digit_next;
      cnt     <= cnt_next;
      an_n    <= an_next;
      seg_n   <= seg_next;
      frame_o <= frame_next;
      // Commit and accept are exclusive on pend_full, so a value taken on the
      // frame-end edge waits for the next frame end instead of being lost.
      if (commit && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (upd_valid && !pend_full) begin
        pend      <= upd_data;
        pend_full <= 1'b1;
      end
    end
  end

  assign upd_ready = !pend_full;

endmodule
